// File: rtl/resolution_upscaler_stream_pkg.sv
// Shared constants, mode enum and bit-offset helpers for the 2x2->3x3 block upscaler.
// Pixel p of block b, channel c sits at ((b*pixels + p)*CH + c)*BPC in a flat stream word.
package upscaler_pkg;

   localparam int IN_PIX  = 4;
   localparam int OUT_PIX = 9;
   localparam int DEF_CH  = 3;
   localparam int DEF_BPC = 8;
   localparam int PIX_W   = DEF_CH * DEF_BPC;

   typedef enum logic {
      UPS_NEAREST  = 1'b0,
      UPS_BILINEAR = 1'b1
   } ups_mode_e;

   function automatic int in_bit(input int b, input int p, input int c, input int ch, input int bpc);
      return ((b * IN_PIX + p) * ch + c) * bpc;
   endfunction

   function automatic int out_bit(input int b, input int q, input int c, input int ch, input int bpc);
      return ((b * OUT_PIX + q) * ch + c) * bpc;
   endfunction

endpackage

// File: rtl/resolution_upscaler_stream_if.sv
// Input/output valid-ready streams, mode select and frame counter of the block upscaler.
// The master modport is the upstream/downstream environment; the slave modport is the upscaler.
interface resolution_upscaler_stream_if
   import upscaler_pkg::*;
#(
   parameter int LANES = 4,
   parameter int CH    = 3,
   parameter int BPC   = 8,
   parameter int CNT_W = 16
);

   localparam int S_W = LANES * IN_PIX * CH * BPC;
   localparam int M_W = LANES * OUT_PIX * CH * BPC;

   logic             mode;
   logic             s_valid;
   logic             s_ready;
   logic [S_W-1:0]   s_data;
   logic             s_last;
   logic             m_valid;
   logic             m_ready;
   logic [M_W-1:0]   m_data;
   logic             m_last;
   logic [CNT_W-1:0] blk_count;

   modport master (
      output mode, s_valid, s_data, s_last, m_ready,
      input  s_ready, m_valid, m_data, m_last, blk_count
   );

   modport slave (
      input  mode, s_valid, s_data, s_last, m_ready,
      output s_ready, m_valid, m_data, m_last, blk_count
   );

endinterface

// File: rtl/resolution_upscaler_stream_kernel.sv
// One block, one channel of the 2x2->3x3 upscaler: stage 1 registers corners and sums, stage 2 the final pixels.
// UPSCALER_ROUND_EN selects round-half-up averages; otherwise averages truncate.
module upscale_kernel_2x2_3x3
   import upscaler_pkg::*;
#(
   parameter int BPC = 8
)
(
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   ld1_i,
   input  logic                   ld2_i,
   input  logic [IN_PIX*BPC-1:0]  pix_i,
   input  ups_mode_e              mode_i,
   output logic [OUT_PIX*BPC-1:0] q_o
);

   localparam int SW = BPC + 2;

`ifdef UPSCALER_ROUND_EN
   localparam logic [SW-1:0] BIAS2 = SW'(1);
   localparam logic [SW-1:0] BIAS4 = SW'(2);
`else
   localparam logic [SW-1:0] BIAS2 = SW'(0);
   localparam logic [SW-1:0] BIAS4 = SW'(0);
`endif

   logic [BPC-1:0] pixIn [IN_PIX];
   logic [BPC-1:0] corner_q [IN_PIX];
   logic [SW-1:0]  sumTop_q, sumBot_q, sumLeft_q, sumRight_q, sumAll_q;
   logic [SW-1:0]  sumTop_d, sumBot_d, sumLeft_d, sumRight_d, sumAll_d;
   logic [BPC-1:0] pixel_d [OUT_PIX];
   logic [BPC-1:0] pixel_q [OUT_PIX];

   always_comb begin
      for (int i = 0; i < IN_PIX; i++) pixIn[i] = pix_i[i*BPC +: BPC];
      sumTop_d   = SW'(pixIn[0]) + SW'(pixIn[1]);
      sumBot_d   = SW'(pixIn[2]) + SW'(pixIn[3]);
      sumLeft_d  = SW'(pixIn[0]) + SW'(pixIn[2]);
      sumRight_d = SW'(pixIn[1]) + SW'(pixIn[3]);
      sumAll_d   = SW'(pixIn[0]) + SW'(pixIn[1]) + SW'(pixIn[2]) + SW'(pixIn[3]);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < IN_PIX; i++) corner_q[i] <= '0;
         sumTop_q   <= '0;
         sumBot_q   <= '0;
         sumLeft_q  <= '0;
         sumRight_q <= '0;
         sumAll_q   <= '0;
      end else if (ld1_i) begin
         for (int i = 0; i < IN_PIX; i++) corner_q[i] <= pixIn[i];
         sumTop_q   <= sumTop_d;
         sumBot_q   <= sumBot_d;
         sumLeft_q  <= sumLeft_d;
         sumRight_q <= sumRight_d;
         sumAll_q   <= sumAll_d;
      end
   end

   // Sums carry two guard bits, so bias-add-and-shift always fits back into BPC bits.
   always_comb begin
      for (int i = 0; i < OUT_PIX; i++) pixel_d[i] = '0;
      pixel_d[0] = corner_q[0];
      pixel_d[2] = corner_q[1];
      pixel_d[6] = corner_q[2];
      pixel_d[8] = corner_q[3];
      if (mode_i == UPS_BILINEAR) begin
         pixel_d[1] = BPC'((sumTop_q   + BIAS2) >> 1);
         pixel_d[7] = BPC'((sumBot_q   + BIAS2) >> 1);
         pixel_d[3] = BPC'((sumLeft_q  + BIAS2) >> 1);
         pixel_d[5] = BPC'((sumRight_q + BIAS2) >> 1);
         pixel_d[4] = BPC'((sumAll_q   + BIAS4) >> 2);
      end else begin
         pixel_d[1] = corner_q[0];
         pixel_d[3] = corner_q[0];
         pixel_d[4] = corner_q[0];
         pixel_d[5] = corner_q[1];
         pixel_d[7] = corner_q[2];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < OUT_PIX; i++) pixel_q[i] <= '0;
      end else if (ld2_i) begin
         for (int i = 0; i < OUT_PIX; i++) pixel_q[i] <= pixel_d[i];
      end
   end

   always_comb begin
      for (int i = 0; i < OUT_PIX; i++) q_o[i*BPC +: BPC] = pixel_q[i];
   end

endmodule

// File: rtl/resolution_upscaler_stream.sv
// Streaming two-stage 2x2->3x3 upscaler: LANES blocks per beat, valid/ready in and out, per-frame beat counter.
// Averaging rounds half up when UPSCALER_ROUND_EN is defined (handled inside the kernel), truncates otherwise.
module resolution_upscaler_stream
   import upscaler_pkg::*;
#(
   parameter int LANES = 4,
   parameter int CH    = 3,
   parameter int BPC   = 8,
   parameter int CNT_W = 16
)
(
   input logic clk,
   input logic resetn,
   resolution_upscaler_stream_if.slave bus
);

   localparam int M_W = LANES * OUT_PIX * CH * BPC;

   logic             v1_q, v1_d, v2_q, v2_d;
   logic             last1_q, last1_d, last2_q, last2_d;
   ups_mode_e        mode1_q, mode1_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             adv1, adv2, sReady, acc, ld2, xfer;
   logic [M_W-1:0]   mData;

   // Each stage may load whenever the stage after it is empty or draining, so a full pipe still streams.
   always_comb begin
      adv2   = !v2_q || bus.m_ready;
      adv1   = !v1_q || adv2;
      sReady = resetn && adv1;
      acc    = bus.s_valid && sReady;
      ld2    = adv2 && v1_q;
      xfer   = v2_q && bus.m_ready;
   end

   always_comb begin
      v1_d    = v1_q;
      v2_d    = v2_q;
      mode1_d = mode1_q;
      last1_d = last1_q;
      last2_d = last2_q;
      cnt_d   = cnt_q;
      if (adv1) begin
         v1_d = acc;
         if (acc) begin
            mode1_d = ups_mode_e'(bus.mode);
            last1_d = bus.s_last;
         end
      end
      if (adv2) begin
         v2_d = v1_q;
         if (v1_q) last2_d = last1_q;
      end
      if (xfer) cnt_d = last2_q ? '0 : cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         mode1_q <= UPS_NEAREST;
         last1_q <= 1'b0;
         last2_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         v1_q    <= v1_d;
         v2_q    <= v2_d;
         mode1_q <= mode1_d;
         last1_q <= last1_d;
         last2_q <= last2_d;
         cnt_q   <= cnt_d;
      end
   end

   for (genvar b = 0; b < LANES; b++) begin : g_lane
      for (genvar c = 0; c < CH; c++) begin : g_ch
         logic [IN_PIX*BPC-1:0]  kPix;
         logic [OUT_PIX*BPC-1:0] kOut;

         for (genvar p = 0; p < IN_PIX; p++) begin : g_in
            assign kPix[p*BPC +: BPC] = bus.s_data[in_bit(b, p, c, CH, BPC) +: BPC];
         end

         upscale_kernel_2x2_3x3 #(.BPC(BPC)) u_kernel (
            .clk    (clk),
            .resetn (resetn),
            .ld1_i  (acc),
            .ld2_i  (ld2),
            .pix_i  (kPix),
            .mode_i (mode1_q),
            .q_o    (kOut)
         );

         for (genvar q = 0; q < OUT_PIX; q++) begin : g_out
            assign mData[out_bit(b, q, c, CH, BPC) +: BPC] = kOut[q*BPC +: BPC];
         end
      end
   end

   assign bus.s_ready   = sReady;
   assign bus.m_valid   = v2_q;
   assign bus.m_last    = last2_q;
   assign bus.m_data    = mData;
   assign bus.blk_count = cnt_q;

endmodule

// File: tb/tb_resolution_upscaler_stream.sv
// Scoreboard bench for the 2x2->3x3 stream upscaler; a second narrow instance exercises counter wrap.
// Expectations follow UPSCALER_ROUND_EN the same way the design build does.
module tb_resolution_upscaler_stream;
   import upscaler_pkg::*;

   localparam int LANES  = 2;
   localparam int CH     = 3;
   localparam int BPC    = 8;
   localparam int CNT_W  = 16;
   localparam int DW_IN  = LANES * IN_PIX * CH * BPC;
   localparam int DW_OUT = LANES * OUT_PIX * CH * BPC;
   localparam int W_CNT  = 2;
   localparam int W_DW   = IN_PIX * 8;

   typedef struct packed {
      logic [DW_OUT-1:0] data;
      logic              last;
   } exp_t;

   logic clk = 1'b0;
   logic resetn = 1'b1;
   always #5 clk = ~clk;

   resolution_upscaler_stream_if #(.LANES(LANES), .CH(CH), .BPC(BPC), .CNT_W(CNT_W)) bus ();
   resolution_upscaler_stream_if #(.LANES(1), .CH(1), .BPC(8), .CNT_W(W_CNT)) wbus ();

   resolution_upscaler_stream #(.LANES(LANES), .CH(CH), .BPC(BPC), .CNT_W(CNT_W)) dut (
      .clk(clk), .resetn(resetn), .bus(bus)
   );

   resolution_upscaler_stream #(.LANES(1), .CH(1), .BPC(8), .CNT_W(W_CNT)) dutW (
      .clk(clk), .resetn(resetn), .bus(wbus)
   );

   exp_t sb[$];
   int   obsCnt[$];
   int   checks = 0;
   int   errors = 0;
   int   expCnt = 0;
   exp_t monE;
   logic monLast;
   logic prevStall = 1'b0;
   logic [DW_OUT-1:0] prevData;
   logic prevLast;

   function automatic logic [DW_OUT-1:0] model(input logic [DW_IN-1:0] d, input logic md);
      logic [DW_OUT-1:0] r;
      int p[4];
      int q[9];
      r = '0;
      for (int b = 0; b < LANES; b++) begin
         for (int c = 0; c < CH; c++) begin
            for (int i = 0; i < 4; i++) p[i] = int'(d[((b*4+i)*CH+c)*BPC +: BPC]);
            q[0] = p[0]; q[2] = p[1]; q[6] = p[2]; q[8] = p[3];
            if (md) begin
`ifdef UPSCALER_ROUND_EN
               q[1] = (p[0] + p[1] + 1) / 2;
               q[7] = (p[2] + p[3] + 1) / 2;
               q[3] = (p[0] + p[2] + 1) / 2;
               q[5] = (p[1] + p[3] + 1) / 2;
               q[4] = (p[0] + p[1] + p[2] + p[3] + 2) / 4;
`else
               q[1] = (p[0] + p[1]) / 2;
               q[7] = (p[2] + p[3]) / 2;
               q[3] = (p[0] + p[2]) / 2;
               q[5] = (p[1] + p[3]) / 2;
               q[4] = (p[0] + p[1] + p[2] + p[3]) / 4;
`endif
            end else begin
               q[1] = p[0]; q[3] = p[0]; q[4] = p[0]; q[5] = p[1]; q[7] = p[2];
            end
            for (int j = 0; j < 9; j++) r[((b*9+j)*CH+c)*BPC +: BPC] = BPC'(q[j]);
         end
      end
      return r;
   endfunction

   function automatic logic [DW_IN-1:0] randBeat();
      logic [DW_IN-1:0] r;
      for (int i = 0; i < DW_IN; i++) r[i] = 1'($urandom_range(1));
      return r;
   endfunction

   function automatic logic [DW_IN-1:0] setPix(input logic [DW_IN-1:0] d, input int lane, input int ch,
                                               input int a, input int b, input int c, input int e);
      logic [DW_IN-1:0] r;
      int v[4];
      r = d;
      v = '{a, b, c, e};
      for (int i = 0; i < 4; i++) r[((lane*4+i)*CH+ch)*BPC +: BPC] = BPC'(v[i]);
      return r;
   endfunction

   function automatic int outPix(input int lane, input int ch, input int q);
      return int'(bus.m_data[((lane*9+q)*CH+ch)*BPC +: BPC]);
   endfunction

   // Monitor: every output transfer is matched against the scoreboard and the frame counter model.
   always @(negedge clk) begin
      if (!resetn) begin
         expCnt    = 0;
         prevStall = 1'b0;
      end else begin
         if (prevStall) begin
            checks++;
            if (bus.m_data !== prevData || bus.m_last !== prevLast) begin
               errors++;
               $display("[TB] FAIL stall_hold: data/last changed while stalled, last got %0b was %0b", bus.m_last, prevLast);
            end
         end
         if (bus.m_valid && bus.m_ready) begin
            monLast = bus.m_last;
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("[TB] FAIL sb_unexpected: output beat with no expected entry");
            end else begin
               monE    = sb.pop_front();
               monLast = monE.last;
               if (bus.m_data !== monE.data) begin
                  errors++;
                  $display("[TB] FAIL sb_data: got %h expected %h", bus.m_data, monE.data);
               end
               checks++;
               if (bus.m_last !== monE.last) begin
                  errors++;
                  $display("[TB] FAIL sb_last: got %0b expected %0b", bus.m_last, monE.last);
               end
            end
            checks++;
            if (bus.blk_count !== CNT_W'(expCnt)) begin
               errors++;
               $display("[TB] FAIL blk_count: got %0d expected %0d", bus.blk_count, expCnt);
            end
            obsCnt.push_back(int'(bus.blk_count));
            expCnt = monLast ? 0 : (expCnt + 1) % (1 << CNT_W);
         end
         prevStall = bus.m_valid && !bus.m_ready;
         prevData  = bus.m_data;
         prevLast  = bus.m_last;
      end
   end

   task automatic send_beat(input logic [DW_IN-1:0] d, input logic l, input logic md);
      int waitCnt;
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      bus.s_last  = l;
      bus.mode    = md;
      sb.push_back('{data: model(d, md), last: l});
      waitCnt = 0;
      @(negedge clk);
      while (!bus.s_ready && waitCnt < 100) begin
         waitCnt++;
         @(negedge clk);
      end
      if (waitCnt >= 100) begin
         checks++;
         errors++;
         $display("[TB] FAIL send_timeout: s_ready stayed %0b", bus.s_ready);
      end
      @(posedge clk);
      #1;
      bus.s_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      @(negedge clk);
      while ((sb.size() != 0 || bus.m_valid) && n < 200) begin
         n++;
         @(negedge clk);
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: %0d beats outstanding, expected 0", sb.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      bus.s_valid  = 1'b0;
      bus.m_ready  = 1'b1;
      wbus.s_valid = 1'b0;
      wbus.m_ready = 1'b1;
      resetn = 1'b0;
      sb.delete();
      repeat (3) @(posedge clk);
      #1;
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.mode = 1'b0; bus.m_ready = 1'b1; bus.s_data = '0;
      wbus.s_valid = 1'b0; wbus.s_last = 1'b0; wbus.mode = 1'b0; wbus.m_ready = 1'b1; wbus.s_data = '0;
      #2 resetn = 1'b0;
      @(negedge clk);
      checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_s_ready: got %0b expected 0", bus.s_ready); end
      checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_m_valid: got %0b expected 0", bus.m_valid); end
      checks++; if (bus.m_last !== 1'b0) begin errors++; $display("[TB] FAIL rst_m_last: got %0b expected 0", bus.m_last); end
      checks++; if (bus.m_data !== '0) begin errors++; $display("[TB] FAIL rst_m_data: got %h expected 0", bus.m_data); end
      checks++; if (bus.blk_count !== '0) begin errors++; $display("[TB] FAIL rst_blk_count: got %0d expected 0", bus.blk_count); end
      @(posedge clk);
      #1 resetn = 1'b1;
      @(negedge clk);
      checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_release_s_ready: got %0b expected 1", bus.s_ready); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_bilinear();
      int exp1[9] = '{10, 15, 20, 20, 25, 30, 30, 35, 40};
`ifdef UPSCALER_ROUND_EN
      int exp2[9] = '{0, 1, 1, 1, 1, 1, 1, 1, 1};
`else
      int exp2[9] = '{0, 0, 1, 0, 0, 1, 1, 1, 1};
`endif
      int n;
      bus.m_ready = 1'b1;
      send_beat(setPix(randBeat(), 0, 0, 10, 20, 30, 40), 1'b0, 1'b1);
      @(negedge clk);
      checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("[TB] FAIL latency_early: m_valid %0b expected 0", bus.m_valid); end
      @(negedge clk);
      checks++; if (bus.m_valid !== 1'b1) begin errors++; $display("[TB] FAIL latency: m_valid %0b expected 1", bus.m_valid); end
      for (int q = 0; q < 9; q++) begin
         checks++;
         if (outPix(0, 0, q) !== exp1[q]) begin
            errors++;
            $display("[TB] FAIL bilinear_q%0d: got %0d expected %0d", q, outPix(0, 0, q), exp1[q]);
         end
      end
      wait_drain();
      send_beat(setPix(randBeat(), 1, 1, 0, 1, 1, 1), 1'b0, 1'b1);
      n = 0;
      @(negedge clk);
      while (!bus.m_valid && n < 20) begin n++; @(negedge clk); end
      for (int q = 0; q < 9; q++) begin
         checks++;
         if (outPix(1, 1, q) !== exp2[q]) begin
            errors++;
            $display("[TB] FAIL bilinear_small_q%0d: got %0d expected %0d", q, outPix(1, 1, q), exp2[q]);
         end
      end
      wait_drain();
   endtask

   task automatic test_nearest();
      int exp3[9] = '{255, 255, 0, 255, 255, 0, 128, 128, 7};
      int n;
      bus.m_ready = 1'b1;
      send_beat(setPix(randBeat(), 1, 2, 255, 0, 128, 7), 1'b0, 1'b0);
      n = 0;
      @(negedge clk);
      while (!bus.m_valid && n < 20) begin n++; @(negedge clk); end
      checks++; if (bus.m_valid !== 1'b1) begin errors++; $display("[TB] FAIL nearest_timeout: m_valid %0b expected 1", bus.m_valid); end
      for (int q = 0; q < 9; q++) begin
         checks++;
         if (outPix(1, 2, q) !== exp3[q]) begin
            errors++;
            $display("[TB] FAIL nearest_q%0d: got %0d expected %0d", q, outPix(1, 2, q), exp3[q]);
         end
      end
      wait_drain();
   endtask

   task automatic test_back_to_back();
      bus.m_ready = 1'b1;
      for (int i = 0; i < 8; i++) send_beat(randBeat(), 1'b0, 1'(i % 2));
      wait_drain();
   endtask

   task automatic test_backpressure();
      fork
         begin
            for (int i = 0; i < 5; i++) send_beat(randBeat(), 1'b0, 1'($urandom_range(1)));
         end
         begin
            bus.m_ready = 1'b0;
            repeat (3) @(posedge clk);
            @(negedge clk);
            checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_s_ready: got %0b expected 0", bus.s_ready); end
            checks++; if (bus.m_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_m_valid: got %0b expected 1", bus.m_valid); end
            @(posedge clk);
            #1;
            for (int i = 0; i < 12; i++) begin
               bus.m_ready = ~bus.m_ready;
               @(posedge clk);
               #1;
            end
            bus.m_ready = 1'b1;
         end
      join
      wait_drain();
   endtask

   task automatic test_frame();
      int expSeq[5] = '{0, 1, 2, 0, 1};
      apply_reset();
      obsCnt.delete();
      bus.m_ready = 1'b1;
      for (int i = 0; i < 5; i++) send_beat(randBeat(), 1'(i == 2), 1'b1);
      wait_drain();
      checks++;
      if (obsCnt.size() != 5) begin
         errors++;
         $display("[TB] FAIL frame_beats: got %0d transfers expected 5", obsCnt.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (obsCnt[i] != expSeq[i]) begin
               errors++;
               $display("[TB] FAIL frame_cnt%0d: got %0d expected %0d", i, obsCnt[i], expSeq[i]);
            end
         end
      end
      checks++; if (bus.blk_count !== CNT_W'(2)) begin errors++; $display("[TB] FAIL frame_final: got %0d expected 2", bus.blk_count); end
   endtask

   task automatic test_wrap();
      int seen[$];
      int expSeq[5] = '{0, 1, 2, 3, 0};
      wbus.m_ready = 1'b1;
      fork
         begin
            wbus.s_valid = 1'b1;
            wbus.s_last  = 1'b0;
            wbus.mode    = 1'b1;
            wbus.s_data  = W_DW'($urandom);
            repeat (5) @(posedge clk);
            #1 wbus.s_valid = 1'b0;
         end
         begin
            repeat (20) begin
               @(negedge clk);
               if (wbus.m_valid && wbus.m_ready) seen.push_back(int'(wbus.blk_count));
            end
         end
      join
      checks++;
      if (seen.size() != 5) begin
         errors++;
         $display("[TB] FAIL wrap_beats: got %0d transfers expected 5", seen.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (seen[i] != expSeq[i]) begin
               errors++;
               $display("[TB] FAIL wrap_cnt%0d: got %0d expected %0d", i, seen[i], expSeq[i]);
            end
         end
      end
      checks++; if (wbus.blk_count !== W_CNT'(1)) begin errors++; $display("[TB] FAIL wrap_final: got %0d expected 1", wbus.blk_count); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_midstream();
      int stale;
      bus.m_ready = 1'b0;
      send_beat(randBeat(), 1'b0, 1'b1);
      send_beat(randBeat(), 1'b1, 1'b0);
      resetn = 1'b0;
      #1;
      sb.delete();
      checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_m_valid: got %0b expected 0", bus.m_valid); end
      checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("[TB] FAIL midrst_s_ready: got %0b expected 0", bus.s_ready); end
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
      bus.m_ready = 1'b1;
      stale = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.m_valid !== 1'b0) stale++;
      end
      checks++; if (stale != 0) begin errors++; $display("[TB] FAIL midrst_stale: got %0d stale cycles expected 0", stale); end
      checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_release: s_ready %0b expected 1", bus.s_ready); end
      checks++; if (bus.blk_count !== '0) begin errors++; $display("[TB] FAIL midrst_cnt: got %0d expected 0", bus.blk_count); end
   endtask

   initial begin
      test_reset();
      test_bilinear();
      test_nearest();
      test_back_to_back();
      test_backpressure();
      test_frame();
      test_wrap();
      test_reset_midstream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
